// File: rtl/t03_display_pkg.sv
`default_nettype none
// =============================================================================
// t03_display_pkg : shared display timing constants and vertical state type.
// Rev 1.0 - initial release
// =============================================================================
package t03_display_pkg;

   typedef enum logic [1:0] {
      V_ACT  = 2'd0,
      V_FP   = 2'd1,
      V_SYNC = 2'd2,
      V_BP   = 2'd3
   } vstate_t;

   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;

   // Line period of the upstream horizontal counter.
   localparam int H_TOTAL = 209;

   localparam int DEF_H_ACTIVE = 160;
   localparam int DEF_H_FP     = 8;
   localparam int DEF_H_SYNC   = 24;
   localparam int DEF_H_BP     = 17;

   localparam int DEF_V_ACTIVE = 120;
   localparam int DEF_V_FP     = 3;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 16;

   localparam bit POL_ACTIVE_LOW  = 1'b0;
   localparam bit POL_ACTIVE_HIGH = 1'b1;
   localparam bit DEF_HS_POL      = POL_ACTIVE_LOW;
   localparam bit DEF_VS_POL      = POL_ACTIVE_LOW;

endpackage
`default_nettype wire

// File: rtl/t03_display_sync_gen_if.sv
`default_nettype none
// =============================================================================
// t03_display_sync_gen_if : horizontal count in, display timing outputs back.
// Rev 1.0 - initial release
// =============================================================================
interface t03_display_sync_gen_if;
   import t03_display_pkg::*;

   logic [H_CNT_W-1:0] h_cnt;
   logic               h_tc;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic [H_CNT_W-1:0] pix_x;
   logic [V_CNT_W-1:0] pix_y;
   logic [V_CNT_W-1:0] v_cnt;
   logic               frame_start;

   modport master (
      output h_cnt, h_tc,
      input  hsync, vsync, de, pix_x, pix_y, v_cnt, frame_start
   );

   modport slave (
      input  h_cnt, h_tc,
      output hsync, vsync, de, pix_x, pix_y, v_cnt, frame_start
   );

endinterface
`default_nettype wire

// File: rtl/t03_display_sync_gen.sv
`default_nettype none
// =============================================================================
// t03_display_sync_gen : vertical line FSM plus registered sync/DE/coordinate decode.
// Rev 1.0 - initial release
// =============================================================================
module t03_display_sync_gen
   import t03_display_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = DEF_HS_POL,
   parameter bit VS_POL   = DEF_VS_POL
)(
   input  wire logic              clk,
   input  wire logic              rst,
   t03_display_sync_gen_if.slave  bus
);

   localparam vstate_t S_ACT  = t03_display_pkg::V_ACT;
   localparam vstate_t S_FP   = t03_display_pkg::V_FP;
   localparam vstate_t S_SYNC = t03_display_pkg::V_SYNC;
   localparam vstate_t S_BP   = t03_display_pkg::V_BP;

   localparam int C_H_SUM = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_SUM = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_CNT_W-1:0] C_H_ACTIVE = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] C_HS_START = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] C_HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_CNT_W-1:0] C_H_LIMIT  = H_CNT_W'(C_H_SUM);

   localparam logic [V_CNT_W-1:0] C_LAST_ACT  = V_CNT_W'(V_ACTIVE - 1);
   localparam logic [V_CNT_W-1:0] C_LAST_FP   = V_CNT_W'(V_FP - 1);
   localparam logic [V_CNT_W-1:0] C_LAST_SYNC = V_CNT_W'(V_SYNC - 1);
   localparam logic [V_CNT_W-1:0] C_LAST_BP   = V_CNT_W'(V_BP - 1);

   // Elaboration-time guard against timing sets that break the upstream line period.
   generate
      if ((C_H_SUM != H_TOTAL) || (C_V_SUM > 1023) ||
          (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
          (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_timing
         $error("t03_display_sync_gen: illegal timing parameters");
      end
   endgenerate

   function automatic logic [V_CNT_W-1:0] f_last_line(input vstate_t s);
      case (s)
         S_ACT:   f_last_line = C_LAST_ACT;
         S_FP:    f_last_line = C_LAST_FP;
         S_SYNC:  f_last_line = C_LAST_SYNC;
         default: f_last_line = C_LAST_BP;
      endcase
   endfunction

   vstate_t             r_vstate;
   logic [V_CNT_W-1:0]  r_phase;
   logic [V_CNT_W-1:0]  r_v_cnt;

   vstate_t             w_vstate_nxt;
   logic [V_CNT_W-1:0]  w_phase_nxt;
   logic [V_CNT_W-1:0]  w_v_cnt_nxt;
   logic                w_last_phase;
   logic                w_wrap;

   logic                w_in_range;
   logic                w_visible;
   logic                w_hs_window;
   logic                w_hsync_nxt;
   logic                w_vsync_nxt;
   logic                w_de_nxt;
   logic [H_CNT_W-1:0]  w_pix_x_nxt;
   logic [V_CNT_W-1:0]  w_pix_y_nxt;
   logic                w_fs_nxt;

   logic                r_hsync;
   logic                r_vsync;
   logic                r_de;
   logic [H_CNT_W-1:0]  r_pix_x;
   logic [V_CNT_W-1:0]  r_pix_y;
   logic                r_frame_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vstate <= S_ACT;
         r_phase  <= '0;
         r_v_cnt  <= '0;
      end else begin
         r_vstate <= w_vstate_nxt;
         r_phase  <= w_phase_nxt;
         r_v_cnt  <= w_v_cnt_nxt;
      end
   end

   always_comb begin
      w_vstate_nxt = r_vstate;
      w_phase_nxt  = r_phase;
      w_v_cnt_nxt  = r_v_cnt;
      w_last_phase = (r_phase == f_last_line(r_vstate));
      w_wrap       = 1'b0;
      if (bus.h_tc) begin
         if (w_last_phase) begin
            w_phase_nxt = '0;
            case (r_vstate)
               S_ACT:   w_vstate_nxt = S_FP;
               S_FP:    w_vstate_nxt = S_SYNC;
               S_SYNC:  w_vstate_nxt = S_BP;
               default: w_vstate_nxt = S_ACT;
            endcase
         end else begin
            w_phase_nxt = r_phase + V_CNT_W'(1);
         end
         w_wrap      = w_last_phase && (r_vstate == S_BP);
         w_v_cnt_nxt = w_wrap ? '0 : r_v_cnt + V_CNT_W'(1);
      end
   end

   // The next-state values equal the current ones off h_tc, so pixel 0 of a line
   // is decoded with that line's vertical state rather than the previous line's.
   always_comb begin
      w_in_range  = (bus.h_cnt < C_H_LIMIT);
      w_visible   = w_in_range && (bus.h_cnt < C_H_ACTIVE);
      w_hs_window = w_in_range && (bus.h_cnt >= C_HS_START) && (bus.h_cnt < C_HS_END);
      w_de_nxt    = w_visible && (w_vstate_nxt == S_ACT);
      w_hsync_nxt = w_hs_window ? HS_POL : ~HS_POL;
      w_vsync_nxt = (w_vstate_nxt == S_SYNC) ? VS_POL : ~VS_POL;
      w_pix_x_nxt = w_de_nxt ? bus.h_cnt : '0;
      w_pix_y_nxt = (w_vstate_nxt == S_ACT) ? w_v_cnt_nxt : '0;
      w_fs_nxt    = bus.h_tc && w_wrap && (bus.h_cnt == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_de          <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_de          <= w_de_nxt;
         r_pix_x       <= w_pix_x_nxt;
         r_pix_y       <= w_pix_y_nxt;
         r_frame_start <= w_fs_nxt;
      end
   end

   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.de          = r_de;
   assign bus.pix_x       = r_pix_x;
   assign bus.pix_y       = r_pix_y;
   assign bus.v_cnt       = r_v_cnt;
   assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_t03_display_sync_gen.sv
`default_nettype none
// =============================================================================
// tb_t03_display_sync_gen : random-stimulus bench with a line-arithmetic reference model.
// Rev 1.0 - initial release
// =============================================================================
module tb_t03_display_sync_gen;

   localparam logic [34:0] RST_VEC = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 10'd0, 1'b0};

   logic clk = 1'b0;
   logic rst;

   t03_display_sync_gen_if bus();

   t03_display_sync_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int m_line   = 0;
   int hc       = 0;

   bit tally_en = 1'b0;
   int de5 = 0, sumx5 = 0, hs5 = 0, hs5_min = 9999, hs5_max = -1;
   int vs_cnt = 0, vs_min = 9999, vs_max = -1, de_tot = 0, max_v = 0;
   int fs_cnt = 0;
   bit fs_ok  = 1'b0;
   bit last_fs = 1'b0;

   function automatic logic [34:0] dut_vec();
      return {bus.hsync, bus.vsync, bus.de, bus.pix_x, bus.pix_y, bus.v_cnt, bus.frame_start};
   endfunction

   task automatic check_eq(input string nm, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // One clock: present inputs, advance the line model on the edge, compare every output.
   task automatic cycle(input int h, input bit tc);
      logic [34:0] e;
      logic [34:0] a;
      bit in_act, e_de, e_hs, e_vs, e_fs;
      int e_px, e_py;
      bus.h_cnt = 11'(h);
      bus.h_tc  = tc;
      @(posedge clk);
      if (rst) begin
         m_line = 0;
         e      = RST_VEC;
      end else begin
         if (tc) m_line = (m_line + 1) % 143;
         in_act = (m_line < 120);
         e_de   = (h < 160) && in_act;
         e_hs   = (h >= 168 && h < 192) ? 1'b0 : 1'b1;
         e_vs   = (m_line >= 123 && m_line < 127) ? 1'b0 : 1'b1;
         e_px   = e_de ? h : 0;
         e_py   = in_act ? m_line : 0;
         e_fs   = tc && (h == 0) && (m_line == 0);
         e      = {e_hs, e_vs, e_de, 11'(e_px), 10'(e_py), 10'(m_line), e_fs};
      end
      #1;
      a = dut_vec();
      chk_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL cycle t=%0t h=%0d tc=%0b: got hs=%0b vs=%0b de=%0b x=%0d y=%0d v=%0d fs=%0b, expected hs=%0b vs=%0b de=%0b x=%0d y=%0d v=%0d fs=%0b",
                    $time, h, tc, a[34], a[33], a[32], a[31:21], a[20:11], a[10:1], a[0],
                    e[34], e[33], e[32], e[31:21], e[20:11], e[10:1], e[0]);
      last_fs = bus.frame_start;
      if (tally_en) begin
         if (bus.v_cnt == 10'd5) begin
            if (bus.de && bus.pix_y == 10'd5) begin
               de5++;
               sumx5 += int'(bus.pix_x);
            end
            if (!bus.hsync) begin
               hs5++;
               if (h < hs5_min) hs5_min = h;
               if (h > hs5_max) hs5_max = h;
            end
         end
         if (!bus.vsync) begin
            vs_cnt++;
            if (int'(bus.v_cnt) < vs_min) vs_min = int'(bus.v_cnt);
            if (int'(bus.v_cnt) > vs_max) vs_max = int'(bus.v_cnt);
         end
         if (bus.de) de_tot++;
         if (int'(bus.v_cnt) > max_v) max_v = int'(bus.v_cnt);
         if (bus.frame_start) begin
            fs_cnt++;
            fs_ok = bus.de && (bus.pix_x == 11'd0) && (bus.pix_y == 10'd0) && (bus.v_cnt == 10'd0);
         end
      end
      @(negedge clk);
   endtask

   task automatic step_up();
      cycle(hc, hc == 0);
      hc = (hc == 208) ? 0 : hc + 1;
   endtask

   initial begin
      int guard;
      int tcs;
      int r;
      rst       = 1'b1;
      bus.h_cnt = '0;
      bus.h_tc  = 1'b0;

      @(negedge clk);
      #1;
      check_eq("reset_values", longint'(dut_vec()), longint'(RST_VEC));
      for (int i = 0; i < 3; i++) cycle(0, 1'b0);
      rst = 1'b0;

      // Frame 0: the reset-time line is line 0, so the wrap lands on the 143rd h_tc.
      hc = 1;
      tally_en = 1'b1;
      for (int i = 0; i < 143 * 209; i++) step_up();
      tally_en = 1'b0;
      check_eq("line5_de_count", de5, 160);
      check_eq("line5_pix_x_sum", sumx5, 12720);
      check_eq("line5_hsync_low", hs5, 24);
      check_eq("line5_hsync_first", hs5_min, 168);
      check_eq("line5_hsync_last", hs5_max, 191);
      check_eq("frame_vsync_low", vs_cnt, 836);
      check_eq("vsync_first_line", vs_min, 123);
      check_eq("vsync_last_line", vs_max, 126);
      check_eq("frame_de_total", de_tot, 19200);
      check_eq("v_cnt_max", max_v, 142);
      check_eq("frame_start_count", fs_cnt, 1);
      check_eq("frame_start_aligned", fs_ok, 1);

      for (int i = 0; i < 36; i++) step_up();
      cycle(37, 1'b1);
      hc = 38;
      check_eq("stray_tc_v_cnt", bus.v_cnt, 1);
      cycle(250, 1'b0);
      check_eq("oor_de", bus.de, 0);
      check_eq("oor_hsync", bus.hsync, 1);

      // Random corruption of counts and stray pulses, stopped shortly before line 60.
      guard = 0;
      while (!(m_line == 60 && hc == 80)) begin
         guard++;
         if (guard > 70 * 209) begin
            check_eq("reach_line60_timeout", guard, 0);
            break;
         end
         r = int'($urandom_range(0, 255));
         if (m_line < 58 && r < 4)       cycle(int'($urandom_range(0, 2047)), 1'b0);
         else if (m_line < 58 && r == 4) cycle(int'($urandom_range(1, 208)), 1'b1);
         else                            cycle(hc, hc == 0);
         hc = (hc == 208) ? 0 : hc + 1;
      end

      step_up();
      #($urandom_range(1, 4));
      rst = 1'b1;
      #1;
      check_eq("async_reset_mid_frame", longint'(dut_vec()), longint'(RST_VEC));
      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle(0, 1'b0);
      rst = 1'b0;

      hc = 1;
      tcs = 0;
      last_fs = 1'b0;
      guard = 0;
      while (!last_fs) begin
         guard++;
         if (guard > 150 * 209) begin
            check_eq("frame_start_timeout", guard, 0);
            break;
         end
         if (hc == 0) tcs++;
         step_up();
      end
      check_eq("tc_to_frame_start", tcs, 143);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/t03_display_sync_gen.md
Name: t03_display_sync_gen

Overview:
- Sits directly downstream of the team's horizontal pixel counter.
- Consumes the per-clock horizontal count and its end-of-line pulse, and tracks the vertical line position with a four-phase FSM.
- Produces registered hsync, vsync, data-enable, pixel coordinates and a frame-start pulse for the display output and pixel-fetch logic.

Parameters:
- H_ACTIVE, 160: visible pixels per line.
- H_FP, 8: horizontal front-porch clocks.
- H_SYNC, 24: hsync pulse clocks.
- H_BP, 17: horizontal back-porch clocks. H_ACTIVE+H_FP+H_SYNC+H_BP must equal 209, the upstream line period.
- V_ACTIVE, 120: visible lines.
- V_FP, 3: vertical front-porch lines.
- V_SYNC, 4: vsync lines.
- V_BP, 16: vertical back-porch lines. V_TOTAL = sum ≤ 1023. Every length ≥ 1.
- HS_POL, 0: hsync active level (0 = active-low).
- VS_POL, 0: vsync active level (0 = active-low).

Ports:
- clk  input  1  system/pixel clock
- rst  input  1  asynchronous, active-high reset
- h_cnt  input  11  upstream horizontal count, 0..208
- h_tc  input  1  upstream end-of-line pulse; one clock wide, coincident with h_cnt==0, period 209 clocks
- hsync  output  1  horizontal sync, level per HS_POL
- vsync  output  1  vertical sync, level per VS_POL
- de  output  1  data enable; high only for visible pixels
- pix_x  output  11  visible column; 0 when de=0
- pix_y  output  10  visible row; 0 outside V_ACTIVE
- v_cnt  output  10  absolute line index, 0..V_TOTAL-1
- frame_start  output  1  one-clock pulse on the first pixel of line 0

Behaviour:
- Reset: async, active-high, all state registered.
  - vstate=V_ACT, phase_cnt=0, v_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL (inactive levels).
  - de=0, pix_x=0, pix_y=0, frame_start=0.
- Vertical FSM states: V_ACT, V_FP, V_SYNC, V_BP. phase_cnt counts lines within the current state.
  - Advance only on h_tc=1. If phase_cnt == len(state)-1: go to the next state in order (V_BP wraps to V_ACT) and set phase_cnt=0. Otherwise phase_cnt+1.
  - v_cnt increments on each h_tc; it wraps to 0 exactly when V_BP → V_ACT.
  - h_tc is authoritative: a line advances on h_tc even if h_cnt≠0.
- Outputs are registered with 1 clock of latency. Outputs at edge k+1 describe the h_cnt sampled at edge k, combined with the vertical state that is valid for that line.
  - On an h_tc clock, use the next vertical state and next v_cnt, so pixel 0 of line n carries line n's timing.
- Horizontal decode, per sampled h_cnt:
  - visible: h_cnt < H_ACTIVE.
  - hsync active: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - h_cnt ≥ 209 (out of range): treated as blanking; hsync inactive, de=0.
- Output rules:
  - de = visible AND (vertical state == V_ACT).
  - pix_x = h_cnt when de, else 0.
  - pix_y = v_cnt while in V_ACT, else 0.
  - vsync is active for the entire V_SYNC state, switching on the same clock as pixel 0 of the first sync line.
- frame_start = 1 for exactly one clock, coincident with de=1, pix_x=0, pix_y=0. It is not asserted for the reset-time line 0.
- Reset mid-frame: outputs return to reset values immediately. Counting restarts at line 0; the upstream counter restarts in lockstep.
- Width rules:
  - All comparisons are unsigned 11-bit.
  - v_cnt and phase_cnt are 10-bit.
  - No arithmetic may overflow for legal parameters.

Decomposition:
- Shared package t03_display_pkg holds:
  - the vstate_t enum (V_ACT, V_FP, V_SYNC, V_BP);
  - H_TOTAL=209 and the default H/V timing constants;
  - the polarity constants.
  The upstream counter and fetch logic share these constants.
- Single module; no sub-module needed. The horizontal decode is a small combinational block inside it.

Test Plan:
- Reset: hold rst for 3 clocks at random phase → all outputs at reset values (hsync=1, vsync=1, de=0, pix_x=0, pix_y=0, v_cnt=0, frame_start=0). Release → line 0 counts from the next h_tc.
- Line timing: drive h_cnt 0..208 with h_tc at h_cnt==0, on line 5 → de=1 for sampled h_cnt 0..159 (pix_x 0..159, pix_y=5), seen 1 clock later. hsync low for sampled h_cnt 168..191 only (24 clocks).
- Vertical phases: run a full frame of 143 lines → de active on lines 0..119. vsync low for lines 123..126, exactly 4×209 clocks. v_cnt wraps 142→0.
- Frame start: on the wrap → frame_start high exactly 1 clock, same clock as de=1, pix_x=0, pix_y=0. Never asserted at any other point in 3 frames.
- Out-of-range and stray pulse: h_cnt=250 → de=0, hsync inactive. h_tc asserted with h_cnt=37 → v_cnt still increments by 1.
- Mid-frame reset: assert rst during line 60, pixel 80 → outputs reset asynchronously (before the next clock edge). After release, line counting restarts at 0 and the next frame_start comes after 143 h_tc pulses.
